subs_layer_seq: RTL



---
 rtl/subs_seq_pkg.sv | 29 ++
 rtl/subs_layer_seq_sbox_slice.sv | 23 ++
 rtl/subs_layer_seq.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/subs_seq_pkg.sv
// subs_seq_pkg
//   Shared types and constants for the folded substitution-layer sequencer.
//   - state_e  : sequencer states (IDLE, SUB, DONE)
//   - INV_SBOX : PRESENT inverse 4-bit S-box
//   - FWD_SBOX : PRESENT forward 4-bit S-box
//   - nchunk() : number of SLICE-bit chunks that make up a SIZE-bit word
package subs_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    localparam logic [3:0] FWD_SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    function automatic int nchunk(input int size, input int slice);
        return size / slice;
    endfunction

endpackage

// File: rtl/subs_layer_seq_sbox_slice.sv
// sbox_slice
//   Purely combinational SLICE-bit substitution: SLICE/4 parallel 4-bit
//   S-box lookups. dir_i selects the forward (1) or inverse (0) PRESENT box.
//   Ports:
//     chunk_i [SLICE-1:0]  chunk to substitute
//     dir_i                1 = forward S-box, 0 = inverse S-box
//     sub_o   [SLICE-1:0]  substituted chunk, nibble positions preserved
module sbox_slice
    import subs_seq_pkg::*;
#(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] chunk_i,
    input  logic             dir_i,
    output logic [SLICE-1:0] sub_o
);

    for (genvar g = 0; g < SLICE / 4; g++) begin : g_nib
        assign sub_o[4*g +: 4] = dir_i ? FWD_SBOX[chunk_i[4*g +: 4]]
                                       : INV_SBOX[chunk_i[4*g +: 4]];
    end

endmodule

// File: rtl/subs_layer_seq.sv
// subs_layer_seq
//   Folded substitution layer for the decryption round path. A word is
//   accepted over in_valid/in_ready, substituted SLICE bits per cycle through
//   one shared sbox_slice (MSB chunk first, rotating the register left), and
//   returned over out_valid/out_ready.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. in_ready is high only in IDLE; out_valid is
//   high only in DONE, and out_data is held stable there until out_ready.
//
//   Optional feature, macro SUBS_SEQ_FWD_EN: adds in_dir, captured with the
//   word; in_dir=1 substitutes with the forward S-box instead of the inverse.
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     in_valid   upstream word valid
//     in_ready   block can accept a word (IDLE)
//     in_data    SIZE-bit state word
//     in_dir     (SUBS_SEQ_FWD_EN only) 1 = forward S-box
//     out_valid  result valid (DONE)
//     out_ready  downstream accepts the result
//     out_data   substituted word (the data register)
//     busy       high in SUB and DONE
module subs_layer_seq
    import subs_seq_pkg::*;
#(
    parameter int SIZE  = 64,
    parameter int SLICE = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_data,
`ifdef SUBS_SEQ_FWD_EN
    input  logic            in_dir,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            busy
);

    localparam int NCHUNK = nchunk(SIZE, SLICE);
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int LAST   = NCHUNK - 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [SIZE-1:0]   data_q,  data_d;

    logic [SLICE-1:0]  chunk;
    logic [SLICE-1:0]  sub_chunk;
    logic [SIZE-1:0]   shifted;
    logic              sbox_dir;

`ifdef SUBS_SEQ_FWD_EN
    logic dir_q, dir_d;
    assign sbox_dir = dir_q;
`else
    assign sbox_dir = 1'b0;
`endif

    // Always the top chunk: the register rotates left, so after NCHUNK steps
    // every chunk has passed through the slice and sits back in its place.
    assign chunk = data_q[SIZE-1 -: SLICE];

    sbox_slice #(
        .SLICE (SLICE)
    ) u_sbox_slice (
        .chunk_i (chunk),
        .dir_i   (sbox_dir),
        .sub_o   (sub_chunk)
    );

    if (SLICE == SIZE) begin : g_full
        assign shifted = sub_chunk;
    end else begin : g_fold
        assign shifted = {data_q[SIZE-SLICE-1:0], sub_chunk};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
`ifdef SUBS_SEQ_FWD_EN
        dir_d     = dir_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
`ifdef SUBS_SEQ_FWD_EN
                    dir_d   = in_dir;
`endif
                    state_d = SUB;
                end
            end
            SUB: begin
                data_d = shifted;
                if (cnt_q == CNT_W'(LAST)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef SUBS_SEQ_FWD_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef SUBS_SEQ_FWD_EN
            dir_q   <= dir_d;
`endif
        end
    end

    assign out_data = data_q;

endmodule
